// File: rtl/odo_div_prog.sv
// odo_div_prog: programmable 50%-duty integer clock divider, N = 2..2^WIDTH-1.
// Ports: clk, rstn; div_val/div_wr divisor write; div_cur/pend/err status;
// tick (posedge period pulse); clk_div; div_en only with ODO_DIV_STOP_EN.
module odo_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 9
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef ODO_DIV_STOP_EN
  input  logic             div_en,
`endif
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_wr,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend,
  output logic             err,
  output logic             tick,
  output logic             clk_div
);

  localparam logic [WIDTH-1:0] RST_N = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] half;
  logic             run;
  logic             p_r;
  logic             n_r;
  logic             go;
  logic             wrap;
  logic             wr_ok;
  logic             wr_bad;

`ifdef ODO_DIV_STOP_EN
  assign go = div_en;
`else
  assign go = 1'b1;
`endif

  assign half    = div_cur >> 1;
  assign cnt_inc = cnt + ONE;
  // An idle divider (after reset or stop) treats every edge as a
  // period boundary, so the first running edge starts a fresh period.
  assign wrap    = !run || (cnt == div_cur - ONE);
  assign wr_ok   = div_wr && (div_val >= TWO);
  assign wr_bad  = div_wr && (div_val < TWO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      run      <= 1'b0;
      p_r      <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
      pend     <= 1'b0;
      pend_val <= RST_N;
      div_cur  <= RST_N;
    end else begin
      err <= wr_bad;
      if (wrap) begin
        // half >= 1 for any legal N, so slot 0 is always high
        cnt  <= '0;
        p_r  <= go;
        tick <= go;
        run  <= go;
        if (pend) div_cur <= pend_val;
      end else begin
        cnt  <= cnt_inc;
        p_r  <= (cnt_inc < half);
        tick <= 1'b0;
      end
      // a write on the boundary edge re-arms pend after the load
      if (wr_ok) begin
        pend_val <= div_val;
        pend     <= 1'b1;
      end else if (wrap) begin
        pend     <= 1'b0;
      end
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) n_r <= 1'b0;
    else       n_r <= p_r;
  end

  // p_r and n_r are both low at every boundary, so the odd
  // flag may change there without a glitch.
  assign clk_div = p_r | (div_cur[0] & n_r);

endmodule

// File: tb/tb_odo_div_prog.sv
// tb_odo_div_prog: scoreboard bench for odo_div_prog.
// Model expresses the output as N high half-cycles out of 2N.
module tb_odo_div_prog;

  logic       clk;
  logic       rstn;
  logic [7:0] div_val;
  logic       div_wr;
  logic [7:0] div_cur;
  logic       pend;
  logic       err;
  logic       tick;
  logic       clk_div;
`ifdef ODO_DIV_STOP_EN
  logic       div_en;
`endif

  odo_div_prog #(.WIDTH(8), .RESET_DIV(9)) dut (
    .clk     (clk),
    .rstn    (rstn),
`ifdef ODO_DIV_STOP_EN
    .div_en  (div_en),
`endif
    .div_val (div_val),
    .div_wr  (div_wr),
    .div_cur (div_cur),
    .pend    (pend),
    .err     (err),
    .tick    (tick),
    .clk_div (clk_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit tk;
    bit c1;
    bit c2;
    bit pd;
    bit er;
    int cur;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  int m_n;
  int m_pv;
  int m_k;
  bit m_pend;
  bit m_run;
  bit m_err;
  bit m_en = 1'b1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n    = 9;
    m_pv   = 0;
    m_k    = 0;
    m_pend = 1'b0;
    m_run  = 1'b0;
    m_err  = 1'b0;
  endtask

  // one clock edge of the reference behaviour
  task automatic step(input bit wr, input int val, input bit en);
    m_err = wr && (val < 2);
    if (!m_run || m_k == m_n - 1) begin
      if (m_pend) begin
        m_n    = m_pv;
        m_pend = 1'b0;
      end
      m_k   = 0;
      m_run = en;
    end else begin
      m_k++;
    end
    if (wr && val >= 2) begin
      m_pv   = val;
      m_pend = 1'b1;
    end
  endtask

  task automatic cyc(input bit wr, input int val);
    exp_t e;
    #2;
    div_wr  = wr;
    div_val = val[7:0];
`ifdef ODO_DIV_STOP_EN
    div_en  = m_en;
`endif
    @(posedge clk);
    step(wr, val, m_en);
    e.tk  = m_run && (m_k == 0);
    e.c1  = m_run && (2 * m_k < m_n);
    e.c2  = m_run && (2 * m_k + 1 < m_n);
    e.pd  = m_pend;
    e.er  = m_err;
    e.cur = m_n;
    q.push_back(e);
    mon_on = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0);
  endtask

  task automatic wait_k(input int t);
    for (int i = 0; i < 300; i++) begin
      if (m_run && m_k == t) break;
      cyc(1'b0, 0);
    end
    if (!(m_run && m_k == t)) begin
      total++;
      bad++;
      $display("FAIL sync: phase %0d never reached", t);
    end
  endtask

  // called at a posedge; asserts reset mid-cycle
  task automatic do_reset();
    #3;
    mon_on = 1'b0;
    rstn   = 1'b0;
    div_wr = 1'b0;
    #1;
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_div_cur", int'(div_cur), 9);
    check("rst_pend", int'(pend), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    q.delete();
    #2;
    rstn = 1'b1;
    model_reset();
  endtask

  // monitor: sample both clock halves, then pop and compare
  initial begin
    exp_t e;
    bit a_tk, a_c1, a_c2, a_pd, a_er;
    int a_cur;
    forever begin
      @(posedge clk);
      #1;
      a_tk  = tick;
      a_c1  = clk_div;
      a_pd  = pend;
      a_er  = err;
      a_cur = int'(div_cur);
      @(negedge clk);
      #1;
      a_c2 = clk_div;
      if (mon_on) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow at %0t: got none want entry", $time);
        end else begin
          e = q.pop_front();
          check("tick", int'(a_tk), int'(e.tk));
          check("clk_div_hi", int'(a_c1), int'(e.c1));
          check("clk_div_lo", int'(a_c2), int'(e.c2));
          check("pend", int'(a_pd), int'(e.pd));
          check("err", int'(a_er), int'(e.er));
          check("div_cur", a_cur, e.cur);
        end
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    div_wr  = 1'b0;
    div_val = '0;
`ifdef ODO_DIV_STOP_EN
    div_en  = 1'b1;
`endif
    model_reset();
    @(posedge clk);
    do_reset();
    idle(30);

    cyc(1'b1, 2);
    idle(20);
    cyc(1'b1, 3);
    idle(20);

    cyc(1'b1, 9);
    idle(20);
    wait_k(3);
    cyc(1'b1, 6);
    wait_k(5);
    cyc(1'b1, 5);
    idle(25);

    cyc(1'b1, 7);
    idle(20);
    wait_k(6);
    cyc(1'b1, 4);
    idle(25);

    cyc(1'b1, 1);
    idle(3);
    cyc(1'b1, 5);
    cyc(1'b1, 0);
    idle(12);

    cyc(1'b1, 8);
    idle(20);
    wait_k(2);
    do_reset();
    idle(20);

`ifdef ODO_DIV_STOP_EN
    wait_k(3);
    m_en = 1'b0;
    idle(15);
    m_en = 1'b1;
    idle(15);
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef ODO_DIV_STOP_EN
      if ($urandom_range(0, 40) == 0) m_en = ~m_en;
`endif
      cyc($urandom_range(0, 5) == 0, int'($urandom_range(0, 12)));
    end
    m_en = 1'b1;
    idle(30);

    @(negedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
